// File: rtl/cellram_pkg.sv
// Shared definitions for the asynchronous CellularRAM controller:
// state encoding, default 50 MHz timing and async-mode tie-off levels.
package cellram_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_READ     = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WRITE    = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_RECOVER  = 3'd6
  } state_t;

  localparam int DEF_POWERUP_CYCLES  = 7500;
  localparam int DEF_READ_CYCLES     = 4;
  localparam int DEF_WRITE_CYCLES    = 4;
  localparam int DEF_RECOVERY_CYCLES = 1;

  // Async mode: no memory clock, ADV# held low, configuration register unused.
  localparam logic MT_CLK_TIE = 1'b0;
  localparam logic MT_ADV_TIE = 1'b0;
  localparam logic MT_CRE_TIE = 1'b0;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cellram_async_ctrl_cycle_timer.sv
// Loadable down-counter that times each controller state; done flags terminal count 0.
// Holds at zero rather than wrapping, so a missed load cannot cause a long stall.
module cellram_cycle_timer #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/cellram_async_ctrl.sv
// Single-word request/ack port to asynchronous CellularRAM strobe sequencer.
// Every output is registered from the next-state decode, so strobes only move on clk edges.
module cellram_async_ctrl
  import cellram_pkg::*;
#(
  parameter int ADDRESS_SIZE    = 24,
  parameter int DATA_SIZE       = 16,
  parameter int POWERUP_CYCLES  = DEF_POWERUP_CYCLES,
  parameter int READ_CYCLES     = DEF_READ_CYCLES,
  parameter int WRITE_CYCLES    = DEF_WRITE_CYCLES,
  parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDRESS_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0]    wdata,
  input  logic [1:0]              be,
  output logic                    ready,
  output logic [DATA_SIZE-1:0]    rdata,
  output logic                    rdata_valid,
  output logic                    wr_ack,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_dq_o,
  input  logic [DATA_SIZE-1:0]    mem_dq_i,
  output logic                    mem_dq_oe,
  output logic                    mem_ce_n,
  output logic                    mem_oe_n,
  output logic                    mem_we_n,
  output logic                    mem_lb_n,
  output logic                    mem_ub_n,
  output logic                    mt_clk,
  output logic                    mt_adv,
  output logic                    mt_cre
);

  localparam int MAX_CYCLES = max4(POWERUP_CYCLES, READ_CYCLES, WRITE_CYCLES, RECOVERY_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0]    mem_dq_o_q, mem_dq_o_d;
  logic [DATA_SIZE-1:0]    rdata_q, rdata_d;
  logic [1:0]              be_q, be_d;
  logic                    rdata_valid_q, rdata_valid_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    ready_q, ready_d;
  logic                    dq_oe_q, dq_oe_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    lb_n_q, lb_n_d;
  logic                    ub_n_q, ub_n_d;

  logic                    tmr_load;
  logic                    tmr_done;
  logic [CNT_W-1:0]        tmr_val;

  cellram_cycle_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(POWERUP_CYCLES - 1))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_dq_o_d    = mem_dq_o_q;
    be_d          = be_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req) begin
          state_d    = we ? ST_WR_SETUP : ST_READ;
          mem_addr_d = addr;
          mem_dq_o_d = wdata;
          be_d       = be;
        end
      end
      ST_READ: begin
        // Capture on the last OE#-low edge, while the memory still drives the bus.
        if (tmr_done) begin
          state_d       = ST_RECOVER;
          rdata_d       = mem_dq_i;
          rdata_valid_d = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        if (tmr_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (tmr_done) state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        if (tmr_done) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Each state entry reloads the timer with its duration minus one.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_INIT:    tmr_val = CNT_W'(POWERUP_CYCLES - 1);
      ST_READ:    tmr_val = CNT_W'(READ_CYCLES - 1);
      ST_WRITE:   tmr_val = CNT_W'(WRITE_CYCLES - 1);
      ST_RECOVER: tmr_val = CNT_W'(RECOVERY_CYCLES - 1);
      default:    tmr_val = '0;
    endcase
  end

  always_comb begin
    ready_d  = 1'b0;
    wr_ack_d = 1'b0;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    case (state_d)
      ST_IDLE: ready_d = 1'b1;
      ST_READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
      ST_WR_SETUP: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        lb_n_d  = ~be_d[0];
        ub_n_d  = ~be_d[1];
      end
      ST_WRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        lb_n_d  = ~be_d[0];
        ub_n_d  = ~be_d[1];
      end
      ST_WR_HOLD: begin
        ce_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        lb_n_d   = ~be_d[0];
        ub_n_d   = ~be_d[1];
        wr_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      mem_addr_q    <= '0;
      mem_dq_o_q    <= '0;
      rdata_q       <= '0;
      be_q          <= '0;
      rdata_valid_q <= 1'b0;
      wr_ack_q      <= 1'b0;
      ready_q       <= 1'b0;
      dq_oe_q       <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      lb_n_q        <= 1'b1;
      ub_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_dq_o_q    <= mem_dq_o_d;
      rdata_q       <= rdata_d;
      be_q          <= be_d;
      rdata_valid_q <= rdata_valid_d;
      wr_ack_q      <= wr_ack_d;
      ready_q       <= ready_d;
      dq_oe_q       <= dq_oe_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      lb_n_q        <= lb_n_d;
      ub_n_q        <= ub_n_d;
    end
  end

  assign ready       = ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign wr_ack      = wr_ack_q;
  assign mem_addr    = mem_addr_q;
  assign mem_dq_o    = mem_dq_o_q;
  assign mem_dq_oe   = dq_oe_q;
  assign mem_ce_n    = ce_n_q;
  assign mem_oe_n    = oe_n_q;
  assign mem_we_n    = we_n_q;
  assign mem_lb_n    = lb_n_q;
  assign mem_ub_n    = ub_n_q;
  assign mt_clk      = MT_CLK_TIE;
  assign mt_adv      = MT_ADV_TIE;
  assign mt_cre      = MT_CRE_TIE;

endmodule

// File: tb/tb_cellram_async_ctrl.sv
// Bench for cellram_async_ctrl: strobe-level memory model, transaction-level expected memory,
// per-cycle timeline expectations derived from the documented latencies.
module tb_cellram_async_ctrl;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int P  = 8;
  localparam int R  = 4;
  localparam int W  = 4;
  localparam int RC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0]    be;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dq_o;
  logic [DW-1:0] mem_dq_i;
  logic          mem_dq_oe;
  logic          mem_ce_n;
  logic          mem_oe_n;
  logic          mem_we_n;
  logic          mem_lb_n;
  logic          mem_ub_n;
  logic          mt_clk;
  logic          mt_adv;
  logic          mt_cre;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem     [256];
  logic [15:0] exp_mem [256];
  logic        mem_init = 1'b1;

  bit          nx_vld = 1'b0;
  logic        nx_we;
  logic [23:0] nx_addr;
  logic [15:0] nx_wdata;
  logic [1:0]  nx_be;

  logic        prev_ce_n = 1'b1;
  logic [23:0] prev_addr = '0;
  int          ce_high_run = 0;
  int          last_gap = 0;

  always #5 clk = ~clk;

  cellram_async_ctrl #(
    .ADDRESS_SIZE(AW), .DATA_SIZE(DW), .POWERUP_CYCLES(P),
    .READ_CYCLES(R), .WRITE_CYCLES(W), .RECOVERY_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_i(mem_dq_i), .mem_dq_oe(mem_dq_oe),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n),
    .mt_clk(mt_clk), .mt_adv(mt_adv), .mt_cre(mt_cre)
  );

  function automatic logic [15:0] seed_word(input int i);
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Strobe-level CellularRAM: byte writes while CE# and WE# are low, drives the bus under OE#.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
    end else if (mem_ce_n == 1'b0 && mem_we_n == 1'b0) begin
      if (!mem_lb_n) mem[mem_addr[7:0]][7:0]  <= mem_dq_o[7:0];
      if (!mem_ub_n) mem[mem_addr[7:0]][15:8] <= mem_dq_o[15:8];
    end
  end

  assign mem_dq_i = (!mem_ce_n && !mem_oe_n && !mem_dq_oe) ? mem[mem_addr[7:0]] : 16'hDEAD;

  always @(negedge clk) begin
    checks++;
    if (!mem_we_n && !mem_oe_n) begin
      errors++;
      $display("FAIL inv_we_oe: we_n=%b oe_n=%b both low at %0t", mem_we_n, mem_oe_n, $time);
    end
    checks++;
    if (mem_dq_oe && !mem_oe_n) begin
      errors++;
      $display("FAIL inv_dq_oe: dq_oe=%b with oe_n=%b at %0t", mem_dq_oe, mem_oe_n, $time);
    end
    if (!prev_ce_n && !mem_ce_n) begin
      checks++;
      if (mem_addr !== prev_addr) begin
        errors++;
        $display("FAIL addr_stable: addr=%h was %h during CE low at %0t", mem_addr, prev_addr, $time);
      end
    end
    if (mem_ce_n) begin
      ce_high_run++;
    end else if (prev_ce_n) begin
      last_gap    = ce_high_run;
      ce_high_run = 0;
    end
    prev_ce_n = mem_ce_n;
    prev_addr = mem_addr;
  end

  // Presents a request and returns in the first cycle after the accepting edge.
  task automatic accept(input logic w, input logic [23:0] a, input logic [15:0] d,
                        input logic [1:0] b, output bit ok);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready=%b required 1 within 200 cycles", ready);
      req = 1'b0;
      return;
    end
    @(negedge clk);
    if (nx_vld) begin
      we = nx_we; addr = nx_addr; wdata = nx_wdata; be = nx_be;
      nx_vld = 1'b0;
    end else begin
      req = 1'b0;
    end
  endtask

  task automatic run_txn(input logic w, input logic [23:0] a, input logic [15:0] d,
                         input logic [1:0] b);
    bit         ok;
    int         kmax;
    logic [6:0] act, exp_v;
    logic [1:0] exp_bytes;
    accept(w, a, d, b, ok);
    if (!ok) return;
    kmax = w ? (W + RC + 3) : (R + RC + 1);
    checks++;
    if (mem_addr !== a) begin
      errors++;
      $display("FAIL txn_addr: mem_addr=%h required %h", mem_addr, a);
    end
    if (w) begin
      checks++;
      if (mem_dq_o !== d) begin
        errors++;
        $display("FAIL txn_wdata: mem_dq_o=%h required %h", mem_dq_o, d);
      end
    end
    for (int k = 1; k <= kmax; k++) begin
      if (k > 1) @(negedge clk);
      act = {mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe, wr_ack, rdata_valid, ready};
      if (w) exp_v = {(k > W + 2), 1'b1, !(k >= 2 && k <= W + 1), (k <= W + 2),
                      (k == W + 2), 1'b0, (k == kmax)};
      else   exp_v = {(k > R), (k > R), 1'b1, 1'b0, 1'b0, (k == R + 1), (k == kmax)};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL timeline %s k=%0d: {ce,oe,we,dq_oe,ack,rv,rdy}=%b required %b",
                 w ? "write" : "read", k, act, exp_v);
      end
      if ((w && k >= 2 && k <= W + 1) || (!w && k <= R)) begin
        exp_bytes = w ? ~b : 2'b00;
        checks++;
        if ({mem_ub_n, mem_lb_n} !== exp_bytes) begin
          errors++;
          $display("FAIL byte_strobes k=%0d: {ub_n,lb_n}=%b required %b", k, {mem_ub_n, mem_lb_n}, exp_bytes);
        end
      end
      if (!w && k == R + 1) begin
        checks++;
        if (rdata !== exp_mem[a[7:0]]) begin
          errors++;
          $display("FAIL read_data addr=%h: rdata=%h required %h", a, rdata, exp_mem[a[7:0]]);
        end
      end
    end
    if (w) begin
      if (b[0]) exp_mem[a[7:0]][7:0]  = d[7:0];
      if (b[1]) exp_mem[a[7:0]][15:8] = d[15:8];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    checks++;
    if ({ready, rdata_valid, wr_ack, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n} !== 9'b0000_11111
        || rdata !== '0 || mem_addr !== '0 || mem_dq_o !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b rv=%b ack=%b oe=%b ce_n=%b oe_n=%b we_n=%b lb_n=%b ub_n=%b rdata=%h addr=%h dq_o=%h required all idle/zero",
               ready, rdata_valid, wr_ack, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n,
               rdata, mem_addr, mem_dq_o);
    end
    rst = 1'b0;
    for (int c = 1; c <= P; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (ready !== 1'b0 || mem_ce_n !== 1'b1) begin
        errors++;
        $display("FAIL init_hold c=%0d: ready=%b ce_n=%b required 0 and 1", c, ready, mem_ce_n);
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready: ready=%b required 1 in cycle %0d", ready, P + 1);
    end
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (mem_ce_n !== 1'b0 || mem_oe_n !== 1'b0) begin
      errors++;
      $display("FAIL init_accept: ce_n=%b oe_n=%b required 0 0", mem_ce_n, mem_oe_n);
    end
    for (int n = 0; n < 50 && ready !== 1'b1; n++) @(negedge clk);
  endtask

  task automatic test_write;
    run_txn(1'b1, 24'h001234, 16'hBEEF, 2'b11);
  endtask

  task automatic test_read;
    run_txn(1'b0, 24'h001234, 16'h0000, 2'b11);
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_beef: rdata=%h required BEEF", rdata);
    end
  endtask

  task automatic test_byte_enables;
    run_txn(1'b1, 24'h000077, 16'h1122, 2'b11);
    run_txn(1'b1, 24'h000077, 16'hAA55, 2'b01);
    run_txn(1'b0, 24'h000077, 16'h0000, 2'b00);
    checks++;
    if (rdata !== 16'h1155) begin
      errors++;
      $display("FAIL be01_merge: rdata=%h required 1155", rdata);
    end
    run_txn(1'b1, 24'h000077, 16'hFFFF, 2'b00);
    run_txn(1'b0, 24'h000077, 16'h0000, 2'b11);
    checks++;
    if (rdata !== 16'h1155) begin
      errors++;
      $display("FAIL be00_nowrite: rdata=%h required 1155", rdata);
    end
  endtask

  task automatic test_back_to_back;
    nx_vld = 1'b1; nx_we = 1'b0; nx_addr = 24'h0000C3; nx_wdata = 16'h0000; nx_be = 2'b11;
    run_txn(1'b1, 24'h0000C3, 16'h0F0F, 2'b11);
    run_txn(1'b0, 24'h0000C3, 16'h0000, 2'b11);
    checks++;
    if (last_gap < 1) begin
      errors++;
      $display("FAIL b2b_gap: ce_n high cycles=%0d required >=1", last_gap);
    end
  endtask

  task automatic test_random;
    logic        tw [24];
    logic [23:0] ta [24];
    logic [15:0] td [24];
    logic [1:0]  tbe[24];
    for (int i = 0; i < 24; i++) begin
      tw[i]  = 1'($urandom_range(0, 1));
      ta[i]  = 24'($urandom_range(0, 255));
      td[i]  = 16'($urandom);
      tbe[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 24; i++) begin
      if (i + 1 < 24 && $urandom_range(0, 1) == 1) begin
        nx_vld = 1'b1; nx_we = tw[i+1]; nx_addr = ta[i+1]; nx_wdata = td[i+1]; nx_be = tbe[i+1];
      end
      run_txn(tw[i], ta[i], td[i], tbe[i]);
    end
  endtask

  task automatic test_reset_mid_write;
    bit ok;
    accept(1'b1, 24'h000042, 16'h1357, 2'b11, ok);
    if (!ok) return;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_we_n, mem_ce_n, mem_dq_oe, wr_ack} !== 4'b1100) begin
      errors++;
      $display("FAIL midrst_strobes: {we_n,ce_n,dq_oe,ack}=%b required 1100",
               {mem_we_n, mem_ce_n, mem_dq_oe, wr_ack});
    end
    rst = 1'b0;
    exp_mem[8'h42] = 16'h1357;
    for (int c = 1; c <= P; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (ready !== 1'b0 || wr_ack !== 1'b0 || rdata_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_init c=%0d: ready=%b ack=%b rv=%b required 0 0 0", c, ready, wr_ack, rdata_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: ready=%b required 1", ready);
    end
    run_txn(1'b0, 24'h000042, 16'h0000, 2'b11);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = seed_word(i);
    test_reset;
    test_write;
    test_read;
    test_byte_enables;
    test_back_to_back;
    test_random;
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cellram_async_ctrl.md
Name: cellram_async_ctrl

Overview:
- Upstream stage of RAM_Interface: converts a single-word request/acknowledge user port into asynchronous-mode CellularRAM strobe sequences.
- Drives outAddress, outData, lowerByte, upperByte, outputEnable and writeEnable, plus chip enable toward mt_ce.
- Enforces power-up delay, access time, write pulse width, data hold and inter-cycle recovery by clock counting.
- Data-bus tristate lives at the top level; this block exposes separate out, in and output-enable signals.

Parameters:
ADDRESS_SIZE, 24, memory word-address width
DATA_SIZE, 16, data word width (bits)
POWERUP_CYCLES, 7500, clocks held in INIT after reset (150 us at 50 MHz)
READ_CYCLES, 4, clocks OE# held low before data capture (>=1)
WRITE_CYCLES, 4, clocks WE# held low (>=1)
RECOVERY_CYCLES, 1, clocks CE# high between accesses (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  1  user request; accepted when req & ready on a rising edge
we  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDRESS_SIZE  word address; sampled with req
wdata  in  DATA_SIZE  write data; sampled with req
be  in  2  byte enables [1]=upper, [0]=lower; sampled with req
ready  out  1  high only in IDLE
rdata  out  DATA_SIZE  read data; valid while rdata_valid=1, held until the next read
rdata_valid  out  1  one-cycle pulse
wr_ack  out  1  one-cycle pulse at write completion
mem_addr  out  ADDRESS_SIZE  to outAddress
mem_dq_o  out  DATA_SIZE  write data to the tristate
mem_dq_i  in  DATA_SIZE  bus readback from the tristate
mem_dq_oe  out  1  1 = FPGA drives the bus
mem_ce_n  out  1  chip enable, active low
mem_oe_n  out  1  output enable, active low
mem_we_n  out  1  write enable, active low
mem_lb_n  out  1  lower byte, active low
mem_ub_n  out  1  upper byte, active low

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=INIT, ready=0, rdata=0, rdata_valid=0, wr_ack=0, mem_dq_oe=0, mem_addr=0, mem_dq_o=0.
- Reset values: all active-low strobes (mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n) = 1.
- All outputs are registered. Strobes change only on clk edges.
- States: INIT, IDLE, READ, WR_SETUP, WRITE, WR_HOLD, RECOVER.
- INIT: count POWERUP_CYCLES, then go to IDLE. req is ignored.
- IDLE: ready=1. On req, register addr, wdata, be and we, then go to READ or WR_SETUP.
- READ (READ_CYCLES clocks):
  - ce_n=0, oe_n=0, we_n=1, lb_n=ub_n=0 regardless of be, dq_oe=0.
  - On the final edge, register mem_dq_i into rdata.
  - Go to RECOVER. rdata_valid=1 in the first RECOVER cycle.
- WR_SETUP (1 clock): ce_n=0, dq_oe=1, we_n=1, oe_n=1. Address and data set up.
- WRITE (WRITE_CYCLES clocks): we_n=0, lb_n=~be[0], ub_n=~be[1].
- WR_HOLD (1 clock): we_n=1, ce_n=0, dq_oe=1, data and address held. wr_ack=1.
- RECOVER (RECOVERY_CYCLES clocks): ce_n=1, oe_n=1, we_n=1, lb_n=ub_n=1, dq_oe=0. Then go to IDLE.
- Latency, read accepted at edge T:
  - T+1..T+READ_CYCLES: READ.
  - rdata_valid high in cycle T+READ_CYCLES+1.
  - ready=1 at T+READ_CYCLES+RECOVERY_CYCLES+1.
- Latency, write accepted at edge T:
  - wr_ack high in cycle T+WRITE_CYCLES+2.
  - ready=1 at T+WRITE_CYCLES+RECOVERY_CYCLES+3.
- Invariants:
  - mem_we_n=0 and mem_oe_n=0 never occur together.
  - mem_dq_oe=1 never coincides with mem_oe_n=0.
  - mem_addr is stable for the whole CE#-low window.
- be=00 write: the full cycle runs with lb_n=ub_n=1 (no bytes written) and wr_ack still pulses.
- req outside IDLE: ignored and not queued; the user must hold req until it sees ready.
- Cycle counter: a single down-counter, width $clog2 of the maximum parameter plus 1. It is loaded on every state entry and never wraps (terminal count 0 advances the state).
- Reset mid-access: on the next edge all strobes go inactive and dq_oe=0. No rdata_valid or wr_ack pulse is produced. INIT reruns the full POWERUP_CYCLES.
- The top level ties off RAM_Interface control lines for async mode: mt_clk=0, mt_adv=0 (ADV# low), mt_cre=0.

Decomposition:
- Shared package cellram_pkg holds:
  - state encoding localparams (INIT..RECOVER);
  - default timing constants for a 50 MHz clock;
  - the async-mode tie-off constants for mt_clk, mt_adv and mt_cre.
- One natural sub-module: cellram_cycle_timer, the loadable down-counter with a done flag.
- The FSM and output registers stay in cellram_async_ctrl.

Test Plan:
Bench parameters: POWERUP_CYCLES=8, READ_CYCLES=4, WRITE_CYCLES=4, RECOVERY_CYCLES=1.
1. Release rst, req=1 held -> ready=0 and strobes inactive for 8 cycles; ready=1 in cycle 9; the request is then accepted.
2. Write addr=0x00_1234, wdata=0xBEEF, be=11 at T -> ce_n=0 from T+1; we_n=0 exactly T+2..T+5; wr_ack at T+6; ce_n=1 at T+7; ready at T+8.
3. Read addr=0x00_1234 with a memory model returning 0xBEEF -> oe_n=0 for T+1..T+4; rdata=0xBEEF with rdata_valid at T+5; ready at T+6.
4. Write be=01, wdata=0xAA55 over a stored 0x1122 -> ub_n stays 1; a read then returns 0x1155. Write be=00 -> memory unchanged and wr_ack still pulses.
5. Back-to-back write then read with req held high -> at least one cycle with ce_n=1 between accesses. Assertion checks hold throughout: no cycle with we_n=0 and oe_n=0 both asserted, and no cycle with dq_oe=1 while oe_n=0.
6. Assert rst during cycle T+3 of a write -> we_n=1, ce_n=1, dq_oe=0 at the next edge; no wr_ack; ready returns only after 8 INIT cycles.
